// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 format constants and packed result type.
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS = 15;
  localparam int SIG_W = 22;
  localparam logic [EXP_W-1:0] EXP_INF = 5'h1f;
  localparam logic [EXP_W-1:0] EXP_ZERO = 5'h00;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;
endpackage

// File: rtl/fp2_norm_round_lzc22.sv
// lzc22: leading-one detector; p_o is the index of the highest set bit, zero_o flags an all-zero input.
module lzc22
  import fp16_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  output logic [4:0]       p_o,
  output logic             zero_o
);
  always_comb begin
    p_o = '0;
    for (int i = 0; i < SIG_W; i++) p_o = sig_i[i] ? i[4:0] : p_o;
  end
  assign zero_o = ~|sig_i;
endmodule

// File: rtl/fp2_norm_round.sv
// fp2_norm_round: normalize, round-to-nearest-even and pack a 22-bit product into a registered binary16.
module fp2_norm_round
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SIG_W-1:0] sig,
  input  logic [EXP_W-1:0] exp,
  input  logic             sign,
  output logic [15:0]      fp_result,
  output logic             under,
  output logic             over
);
  logic [4:0] p;
  logic zero;
  logic [20:0] norm;
  logic [FRAC_W-1:0] frac, frac_r;
  logic guard, sticky, inc, carry;
  logic signed [7:0] e, e_r;
  fp16_t res_d, res_q;
  logic under_d, under_q, over_d, over_q;
  lzc22 u_lzc (.sig_i(sig), .p_o(p), .zero_o(zero));
  // Shifting the 21 bits below the top pushes the hidden 1 out, leaving frac/guard/sticky aligned.
  assign norm = sig[20:0] << (5'd21 - p);
  assign frac = norm[20:11];
  assign guard = norm[10];
  assign sticky = |norm[9:0];
  assign inc = guard & (sticky | frac[0]);
  assign {carry, frac_r} = {1'b0, frac} + {10'd0, inc};
  assign e = $signed({3'b0, exp}) + $signed({3'b0, p}) - 8'sd20;
  assign e_r = e + $signed({7'd0, carry});
  always_comb begin
    over_d = ~zero & (e_r >= 8'sd31);
    under_d = ~zero & (e_r <= 8'sd0);
    res_d = zero | under_d ? '{sign, EXP_ZERO, '0}
          : over_d         ? '{sign, EXP_INF, '0}
          :                  '{sign, e_r[4:0], frac_r};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      under_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      res_q <= res_d;
      under_q <= under_d;
      over_q <= over_d;
    end
  end
  assign fp_result = res_q;
  assign under = under_q;
  assign over = over_q;
endmodule

// File: tb/tb_fp2_norm_round.sv
// tb_fp2_norm_round: directed vectors with hand-computed binary16 results and flags.
module tb_fp2_norm_round;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [21:0] sig = '0;
  logic [4:0] exp = '0;
  logic sign = 1'b0;
  logic [15:0] fp_result;
  logic under, over;
  int checks = 0;
  int errors = 0;

  fp2_norm_round dut (.clk(clk), .rst(rst), .sig(sig), .exp(exp), .sign(sign),
                      .fp_result(fp_result), .under(under), .over(over));

  always #5 clk = ~clk;

  task automatic drive(input logic [21:0] s, input logic [4:0] e, input logic sg);
    @(negedge clk);
    sig = s; exp = e; sign = sg;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(22'h100000, 5'd15, 1'b1);
    checks++;
    if ({fp_result, under, over} !== {16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL reset: got %h/%b/%b want 0000/0/0", fp_result, under, over);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    drive(22'b1011100000111111100000, 5'b10011, 1'b1);
    checks++;
    if ({fp_result, under, over} !== {16'hD1C2, 2'b00}) begin
      errors++;
      $display("FAIL basic: got %h/%b/%b want d1c2/0/0", fp_result, under, over);
    end
  endtask

  task automatic test_unity_zero;
    drive(22'h100000, 5'd15, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h3C00, 2'b00}) begin
      errors++;
      $display("FAIL unity: got %h/%b/%b want 3c00/0/0", fp_result, under, over);
    end
    drive(22'h0, 5'd20, 1'b1);
    checks++;
    if ({fp_result, under, over} !== {16'h8000, 2'b00}) begin
      errors++;
      $display("FAIL zero: got %h/%b/%b want 8000/0/0", fp_result, under, over);
    end
    drive(22'h000001, 5'd31, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h2C00, 2'b00}) begin
      errors++;
      $display("FAIL lsb_only: got %h/%b/%b want 2c00/0/0", fp_result, under, over);
    end
  endtask

  task automatic test_rounding;
    drive(22'h100600, 5'd15, 1'b0);
    checks++;
    if (fp_result !== 16'h3C02) begin
      errors++;
      $display("FAIL tie_odd_up: got %h want 3c02", fp_result);
    end
    drive(22'h100200, 5'd15, 1'b0);
    checks++;
    if (fp_result !== 16'h3C00) begin
      errors++;
      $display("FAIL tie_even_hold: got %h want 3c00", fp_result);
    end
    drive(22'h100201, 5'd15, 1'b0);
    checks++;
    if (fp_result !== 16'h3C01) begin
      errors++;
      $display("FAIL sticky_up: got %h want 3c01", fp_result);
    end
    drive(22'h1FFE00, 5'd15, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h4000, 2'b00}) begin
      errors++;
      $display("FAIL round_carry: got %h/%b/%b want 4000/0/0", fp_result, under, over);
    end
  endtask

  task automatic test_range;
    drive(22'h200000, 5'd30, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h7C00, 2'b01}) begin
      errors++;
      $display("FAIL overflow: got %h/%b/%b want 7c00/0/1", fp_result, under, over);
    end
    drive(22'h3FFFFF, 5'd29, 1'b1);
    checks++;
    if ({fp_result, under, over} !== {16'hFC00, 2'b01}) begin
      errors++;
      $display("FAIL round_overflow: got %h/%b/%b want fc00/0/1", fp_result, under, over);
    end
    drive(22'h1FFC00, 5'd30, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h7BFF, 2'b00}) begin
      errors++;
      $display("FAIL max_normal: got %h/%b/%b want 7bff/0/0", fp_result, under, over);
    end
    drive(22'h080000, 5'd1, 1'b1);
    checks++;
    if ({fp_result, under, over} !== {16'h8000, 2'b10}) begin
      errors++;
      $display("FAIL underflow: got %h/%b/%b want 8000/1/0", fp_result, under, over);
    end
    drive(22'h1FFFFF, 5'd0, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h0400, 2'b00}) begin
      errors++;
      $display("FAIL round_rescue: got %h/%b/%b want 0400/0/0", fp_result, under, over);
    end
    drive(22'h100000, 5'd0, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h0000, 2'b10}) begin
      errors++;
      $display("FAIL e_zero_under: got %h/%b/%b want 0000/1/0", fp_result, under, over);
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] s_t [4] = '{22'h100000, 22'h200000, 22'h100600, 22'h080000};
    logic [4:0]  e_t [4] = '{5'd15, 5'd15, 5'd16, 5'd1};
    logic        g_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [17:0] x_t [4] = '{{16'hBC00, 2'b00}, {16'h4000, 2'b00},
                             {16'h4002, 2'b00}, {16'h0000, 2'b10}};
    for (int i = 0; i < 4; i++) begin
      drive(s_t[i], e_t[i], g_t[i]);
      checks++;
      if ({fp_result, under, over} !== x_t[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h/%b/%b want %h", i, fp_result, under, over, x_t[i]);
      end
    end
    drive(22'h080000, 5'd1, 1'b0);
    checks++;
    if ({fp_result, under, over} !== {16'h0000, 2'b10}) begin
      errors++;
      $display("FAIL hold: got %h/%b/%b want 0000/1/0", fp_result, under, over);
    end
  endtask

  task automatic test_reset_mid;
    drive(22'h200000, 5'd30, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sig = 22'h100000; exp = 5'd15; sign = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({fp_result, under, over} !== {16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: got %h/%b/%b want 0000/0/0", fp_result, under, over);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({fp_result, under, over} !== {16'hBC00, 2'b00}) begin
      errors++;
      $display("FAIL reset_release: got %h/%b/%b want bc00/0/0", fp_result, under, over);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unity_zero();
    test_rounding();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
